fc_seq: RTL and testbench
=========================

FC_SEQ -- requirements
Module: fc_seq

Interface
REQ-001 Parameter N_BEATS, default 36, means MAC beats per inference (3 lanes x 36 = 108 weights per neuron).
REQ-002 Parameter ACC_W, default 8, means signed accumulator width returned by the MAC datapath.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request one inference; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of the current inference.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 feat_rd_en  output  1  feature-buffer read strobe.
REQ-009 feat_addr  output  6  feature-buffer word address, 0..N_BEATS-1.
REQ-010 feat_data  input  6  three 2-bit activation lanes, valid one cycle after feat_rd_en.
REQ-011 mac_clr  output  1  one-cycle accumulator clear to the MAC.
REQ-012 mac_en  output  1  MAC accumulate enable.
REQ-013 mac_idx  output  6  weight-column index for the current beat.
REQ-014 mac_din  output  6  activation lanes for the current beat; equals feat_data when mac_en=1, else 0.
REQ-015 acc0, acc1  input  ACC_W each  signed MAC accumulators (neuron 0 = non-speech, neuron 1 = speech).
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  consumer accepts result.
REQ-018 vad_flag  output  1  speech decision.
REQ-019 score  output  ACC_W+1  signed acc1 - acc0.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, RUN, FLUSH, CAPTURE, OUT.
REQ-021 IDLE with start=1 at cycle 0 SHALL enter RUN; in cycle 1 mac_clr=1, feat_rd_en=1, feat_addr=0.
REQ-022 RUN SHALL last N_BEATS cycles (1..36), issuing feat_rd_en=1 with feat_addr=k in cycle 1+k; mac_clr is high in cycle 1 only.
REQ-023 mac_en and mac_idx SHALL be feat_rd_en and feat_addr delayed one register stage: mac_en=1, mac_idx=k in cycle 2+k.
REQ-024 After the RUN cycle with feat_addr=N_BEATS-1, the FSM SHALL enter FLUSH (cycle 37, final mac_en beat, no read) and then CAPTURE (cycle 38).
REQ-025 CAPTURE SHALL register vad_flag = (acc1 > acc0) and score = acc1 - acc0, both sign-extended to ACC_W+1 bits; a tie gives vad_flag=0.
REQ-026 OUT SHALL assert res_valid from cycle 39, holding vad_flag and score stable until res_valid && res_ready.
REQ-027 Acceptance in OUT SHALL return to IDLE next cycle; start is then accepted no earlier than that IDLE cycle.
REQ-028 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with feat_rd_en, mac_en and res_valid low and no result produced; abort has priority over every other transition.
REQ-030 abort in IDLE SHALL have no effect and SHALL block a simultaneous start.
REQ-031 feat_rd_en and mac_en SHALL never be high in CAPTURE, OUT or IDLE.

Reset
REQ-032 On rst_n=0, the FSM SHALL go to IDLE, the beat counter SHALL go to 0, and every output SHALL go to 0 asynchronously, including mid-inference.
REQ-033 The first start after reset release SHALL behave exactly as REQ-021.

Structure
REQ-034 Package vad_pkg SHALL hold N_BEATS, ACC_W, the fc_seq state enumeration and the feature-address width.
REQ-035 No sub-module is required; the beat counter and the 1-stage read-to-MAC alignment register SHALL be inline.

Verification
REQ-036 Start pulse, memory returns addr-encoded data, MAC model accumulates -> mac_clr in cycle 1, 36 mac_en beats with mac_idx 0..35 in cycles 2..37, res_valid first in cycle 39.
REQ-037 acc0=5, acc1=9 at CAPTURE -> vad_flag=1, score=+4; acc0=-3, acc1=-3 -> vad_flag=0, score=0; acc0=127, acc1=-128 -> score=-255.
REQ-038 res_ready held low 10 cycles after res_valid -> outputs stable, busy=1; res_ready=1 -> IDLE next cycle.
REQ-039 start re-pulsed during RUN and OUT -> ignored, single result only.
REQ-040 abort in cycle 20 -> IDLE in cycle 21, no res_valid; a new start then completes normally.
REQ-041 rst_n low in cycle 15 -> all outputs 0 immediately; after release, a start gives the nominal 39-cycle timing.

Source files
------------

// File: rtl/vad_pkg.sv
// Shared constants and state encoding for the VAD fully-connected sequencer.
package vad_pkg;

  localparam int N_BEATS = 36;
  localparam int ACC_W   = 8;
  localparam int FEAT_AW = 6;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    CAPTURE,
    OUT
  } fc_state_t;

endpackage

// File: rtl/fc_seq.sv
// Sequencer for one two-neuron FC inference: streams feature words into the MAC,
// then registers the speech decision and margin and holds them for a ready/valid consumer.
module fc_seq #(
  parameter int N_BEATS = vad_pkg::N_BEATS,
  parameter int ACC_W   = vad_pkg::ACC_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              feat_rd_en,
  output logic [vad_pkg::FEAT_AW-1:0]       feat_addr,
  input  logic [5:0]                        feat_data,
  output logic                              mac_clr,
  output logic                              mac_en,
  output logic [vad_pkg::FEAT_AW-1:0]       mac_idx,
  output logic [5:0]                        mac_din,
  input  logic signed [ACC_W-1:0]           acc0,
  input  logic signed [ACC_W-1:0]           acc1,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              vad_flag,
  output logic signed [ACC_W:0]             score
);

  import vad_pkg::*;

  localparam logic [FEAT_AW-1:0] LAST_BEAT = FEAT_AW'(N_BEATS - 1);

  fc_state_t          state, state_nxt;
  logic [FEAT_AW-1:0] beat_cnt;
  logic               vld_p1;
  logic [FEAT_AW-1:0] idx_p1;

  // Margin is computed one bit wider so that extreme accumulators cannot wrap.
  function automatic logic signed [ACC_W:0] margin(input logic signed [ACC_W-1:0] a1,
                                                   input logic signed [ACC_W-1:0] a0);
    logic signed [ACC_W:0] a1_ext;
    logic signed [ACC_W:0] a0_ext;
    a1_ext = a1;
    a0_ext = a0;
    return a1_ext - a0_ext;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (beat_cnt == LAST_BEAT) state_nxt = FLUSH;
        FLUSH:   state_nxt = CAPTURE;
        CAPTURE: state_nxt = OUT;
        OUT:     if (res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (state == RUN && !abort) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end else begin
      beat_cnt <= '0;
    end
  end

  assign busy       = (state != IDLE);
  assign feat_rd_en = (state == RUN);
  assign feat_addr  = beat_cnt;
  assign mac_clr    = (state == RUN) && (beat_cnt == '0);

  // p1: read strobe/address aligned with the feature word returned by the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= feat_rd_en && !abort;
      idx_p1 <= feat_addr;
    end
  end

  assign mac_en  = vld_p1;
  assign mac_idx = idx_p1;
  assign mac_din = vld_p1 ? feat_data : '0;

  // result register: loaded once the last beat has settled into the accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vad_flag <= 1'b0;
      score    <= '0;
    end else if (state == CAPTURE && !abort) begin
      vad_flag <= (acc1 > acc0);
      score    <= margin(acc1, acc0);
    end
  end

  assign res_valid = (state == OUT);

endmodule

// File: tb/tb_fc_seq.sv
// Directed bench for fc_seq: beat timing, decision table, handshake hold, abort and reset.
module tb_fc_seq;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              res_ready = 1'b0;
  logic              busy, feat_rd_en, mac_clr, mac_en, res_valid, vad_flag;
  logic [5:0]        feat_addr, feat_data, mac_idx, mac_din;
  logic signed [7:0] acc0 = 8'sd0;
  logic signed [7:0] acc1 = 8'sd0;
  logic signed [8:0] score;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int a0;
    int a1;
    int flag;
    int scr;
  } vec_t;

  fc_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_data(feat_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_idx(mac_idx), .mac_din(mac_din),
    .acc0(acc0), .acc1(acc1), .res_valid(res_valid), .res_ready(res_ready),
    .vad_flag(vad_flag), .score(score)
  );

  always #5 clk = ~clk;

  // Feature buffer: one-cycle read latency, word content derived from its address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          feat_data <= 6'd0;
    else if (feat_rd_en) feat_data <= feat_addr ^ 6'h15;
    else                 feat_data <= 6'h3F;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 80; i++) begin
      if (res_valid) begin
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic run_timing(input string tag);
    int c, clr_n, clr_at, beats, first_en, last_en, rd_n, bad, vcyc;
    clr_n = 0; clr_at = -1; beats = 0; first_en = -1; last_en = -1;
    rd_n = 0; bad = 0; vcyc = -1;
    acc0 = 8'sd0;
    acc1 = 8'sd1;
    pulse_start();
    c = 1;
    for (int i = 0; i < 60; i++) begin
      if (mac_clr) begin clr_n++; clr_at = c; end
      if (feat_rd_en) begin
        rd_n++;
        if (feat_addr != 6'(c - 1)) bad++;
      end
      if (mac_en) begin
        if (first_en < 0) first_en = c;
        last_en = c;
        if (mac_idx != 6'(beats)) bad++;
        if (mac_din != (mac_idx ^ 6'h15)) bad++;
        beats++;
      end else if (mac_din != 6'd0) begin
        bad++;
      end
      if (!busy) bad++;
      if (res_valid) begin
        vcyc = c;
        break;
      end
      tick();
      c++;
    end
    chk({tag, "_clr_cycle"}, clr_at, 1);
    chk({tag, "_clr_count"}, clr_n, 1);
    chk({tag, "_rd_count"}, rd_n, 36);
    chk({tag, "_beats"}, beats, 36);
    chk({tag, "_first_en"}, first_en, 2);
    chk({tag, "_last_en"}, last_en, 37);
    chk({tag, "_beat_errs"}, bad, 0);
    chk({tag, "_valid_cycle"}, vcyc, 39);
    chk({tag, "_flag"}, int'(vad_flag), 1);
    chk({tag, "_score"}, int'(score), 1);
    accept();
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    vec_t vt[5];
    int   cyc, bad, seen;
    logic snap_flag;
    logic signed [8:0] snap_score;

    vt[0] = '{a0: 5,    a1: 9,    flag: 1, scr: 4};
    vt[1] = '{a0: -3,   a1: -3,   flag: 0, scr: 0};
    vt[2] = '{a0: 127,  a1: -128, flag: 0, scr: -255};
    vt[3] = '{a0: -128, a1: 127,  flag: 1, scr: 255};
    vt[4] = '{a0: 0,    a1: -1,   flag: 0, scr: -1};

    // Reset state
    repeat (3) tick();
    chk("rst_ctrl", int'({busy, feat_rd_en, mac_en, mac_clr, res_valid}), 0);
    chk("rst_data", int'({vad_flag, score, feat_addr, mac_idx, mac_din}), 0);
    rst_n = 1'b1;
    tick();

    run_timing("nominal");

    // Decision table
    foreach (vt[k]) begin
      acc0 = 8'(vt[k].a0);
      acc1 = 8'(vt[k].a1);
      pulse_start();
      wait_valid(cyc);
      chk($sformatf("vec%0d_cycle", k), cyc, 39);
      chk($sformatf("vec%0d_flag", k), int'(vad_flag), vt[k].flag);
      chk($sformatf("vec%0d_score", k), int'(score), vt[k].scr);
      accept();
      chk($sformatf("vec%0d_idle", k), int'(busy), 0);
    end

    // Result held while consumer stalls, even if accumulators move
    acc0 = 8'sd5;
    acc1 = 8'sd9;
    pulse_start();
    wait_valid(cyc);
    chk("hold_valid_seen", int'(cyc > 0), 1);
    snap_flag = vad_flag;
    snap_score = score;
    acc0 = 8'sd50;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!res_valid || !busy || vad_flag != snap_flag || score != snap_score) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_score", int'(score), 4);
    accept();
    chk("hold_release", int'({busy, res_valid}), 0);

    // start during RUN and OUT must not queue a second inference
    acc0 = 8'sd1;
    acc1 = 8'sd2;
    pulse_start();
    repeat (9) tick();
    pulse_start();
    wait_valid(cyc);
    chk("restart_valid_seen", int'(cyc > 0), 1);
    pulse_start();
    chk("restart_out_held", int'(res_valid), 1);
    accept();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy || res_valid) seen++;
      tick();
    end
    chk("restart_no_second", seen, 0);

    // abort in cycle 20
    pulse_start();
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_idle", int'({busy, feat_rd_en, mac_en, res_valid}), 0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (busy || res_valid || mac_en) seen++;
      tick();
    end
    chk("abort_no_result", seen, 0);
    run_timing("post_abort");

    // abort in IDLE blocks a simultaneous start
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_block", int'(busy), 0);

    // abort in OUT discards the pending result
    pulse_start();
    wait_valid(cyc);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", int'({busy, res_valid}), 0);

    // asynchronous reset in cycle 15
    pulse_start();
    repeat (14) tick();
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", int'({busy, feat_rd_en, mac_en, mac_clr, res_valid}), 0);
    chk("async_rst_data", int'({vad_flag, score, feat_addr, mac_idx, mac_din}), 0);
    #1;
    rst_n = 1'b1;
    tick();
    run_timing("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
